// File: rtl/key_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, column
// drive patterns, the row-major key-code table and the named key codes.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_SCAN     = 3'd2,
        ST_EMIT     = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] COL_ALL  = 4'b0000;

    // Element k drives column k low; element 0 is the rightmost entry.
    localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [3:0] KEY_EQ  = 4'd10;
    localparam logic [3:0] KEY_CLR = 4'd11;
    localparam logic [3:0] KEY_ADD = 4'd13;

    // Indexed by {row, col}; element 0 (row0/col0) is the rightmost entry.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'd14 - 4'd1, 4'd15, 4'd0, 4'd14,    // row3: 14 0 15 13
        4'd12, 4'd9, 4'd8, 4'd7,             // row2: 7 8 9 12
        KEY_CLR, 4'd6, 4'd5, 4'd4,           // row1: 4 5 6 11
        KEY_EQ, 4'd3, 4'd2, 4'd1             // row0: 1 2 3 10
    };

    // Index of the lowest-numbered row pulled low.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        lowest_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Saturating stability counter shared by press and release debouncing:
// counts consecutive cycles in which the rows match the awaited level.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE = 10
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       wait_high,
    input  logic [3:0] row_s,
    output logic       done
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [CNT_W-1:0] cnt;
    logic             match;

    assign match = wait_high ? (row_s == ROW_IDLE) : (row_s != ROW_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_1khz) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !match) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(DEBOUNCE)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Asserted on the cycle the count reaches DEBOUNCE.
    assign done = match && (cnt == CNT_W'(DEBOUNCE - 1));

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: debounces a press, scans columns to locate the key,
// emits a one-cycle strobe with its code, then waits for a debounced release.
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE = 10,
    parameter int SETTLE   = 3
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       flag,
    output logic [3:0] data
);

    localparam int SET_W = $clog2(SETTLE + 1);

    logic [3:0]       row_m;
    logic [3:0]       row_s;
    state_t           state;
    state_t           state_nxt;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic             sample;
    logic             load;
    logic             db_clear;
    logic             db_wait_high;
    logic             db_done;

    always_ff @(posedge clk_1khz) begin
        if (!rst_n) begin
            row_m <= ROW_IDLE;
            row_s <= ROW_IDLE;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk_1khz  (clk_1khz),
        .rst_n     (rst_n),
        .clear     (db_clear),
        .wait_high (db_wait_high),
        .row_s     (row_s),
        .done      (db_done)
    );

    // Rows only reflect a new column after the sync delay, so sample last.
    assign sample = (state == ST_SCAN) && (settle_cnt == SET_W'(SETTLE - 1));

    always_ff @(posedge clk_1khz) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col_idx    <= 2'd0;
            settle_cnt <= '0;
            data       <= 4'd0;
        end else begin
            state   <= state_nxt;
            col_idx <= col_idx_nxt;
            if (state != ST_SCAN || sample) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SET_W'(SETTLE)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (load) begin
                data <= KEY_MAP[{lowest_low(row_s), col_idx}];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        col_idx_nxt  = col_idx;
        col          = COL_ALL;
        flag         = 1'b0;
        load         = 1'b0;
        db_clear     = 1'b1;
        db_wait_high = 1'b0;
        case (state)
            ST_IDLE: begin
                if (row_s != ROW_IDLE) state_nxt = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                db_clear = 1'b0;
                if (row_s == ROW_IDLE) begin
                    state_nxt = ST_IDLE;
                end else if (db_done) begin
                    state_nxt   = ST_SCAN;
                    col_idx_nxt = 2'd0;
                end
            end
            ST_SCAN: begin
                col = COL_DRIVE[col_idx];
                if (sample) begin
                    if (row_s != ROW_IDLE) begin
                        load      = 1'b1;
                        state_nxt = ST_EMIT;
                    end else if (col_idx == 2'd3) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
            end
            ST_EMIT: begin
                flag      = 1'b1;
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                db_clear     = 1'b0;
                db_wait_high = 1'b1;
                if (db_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl: a 4x4 switch-matrix model drives the rows
// from the pressed-key mask and the DUT column drive.
module tb_key_scan_ctrl;

    logic        clk_1khz;
    logic        rst_n;
    logic [3:0]  row_bus;
    logic [3:0]  col;
    logic        flag;
    logic [3:0]  data;
    logic [15:0] pressed;

    int n_checks = 0;
    int n_fail   = 0;
    int flag_cnt = 0;
    int dbl      = 0;
    int codes[$];
    logic flag_prev  = 1'b0;
    logic col_active = 1'b0;

    key_scan_ctrl #(.DEBOUNCE(10), .SETTLE(3)) dut (
        .clk_1khz (clk_1khz),
        .rst_n    (rst_n),
        .row      (row_bus),
        .col      (col),
        .flag     (flag),
        .data     (data)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    always_comb begin
        row_bus = 4'hf;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row_bus[r] = 1'b0;
            end
        end
    end

    always @(negedge clk_1khz) begin
        if (rst_n) begin
            if (flag) begin
                flag_cnt++;
                codes.push_back(int'(data));
                if (flag_prev) dbl++;
            end
            if (col != 4'b0000) col_active = 1'b1;
            flag_prev = flag;
        end else begin
            flag_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_flag(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk_1khz);
            lat++;
        end while (!flag && lat < budget);
    endtask

    // Press keys at a negedge and check latency (posedges to strobe) and code.
    task automatic press_report(input logic [15:0] mask, input int exp_code,
                                input int exp_lat, input string tag);
        int lat;
        pressed = pressed | mask;
        wait_flag(60, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_code"}, int'(data), exp_code);
    endtask

    task automatic release_all();
        pressed = '0;
        repeat (25) @(negedge clk_1khz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk_1khz);
        check("reset_col", int'(col), 0);
        check("reset_flag", int'(flag), 0);
        check("reset_data", int'(data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_1khz);

        // row1/col1 held 30 cycles: latency 3+D+2S = 19
        press_report(16'h0020, 5, 19, "key5");
        repeat (11) @(negedge clk_1khz);
        release_all();
        check("key5_count", flag_cnt, 1);
        check("key5_col_idle", int'(col), 0);
        check("key5_data_held", int'(data), 5);

        // row3/col3 is the worst case: 2 + D + 4S + 1 = 25
        press_report(16'h8000, 13, 25, "key13");
        release_all();
        press_report(16'h0001, 1, 16, "key1");
        release_all();
        check("seq_count", flag_cnt, 3);
        check("seq_0", codes[0], 5);
        check("seq_1", codes[1], 13);
        check("seq_2", codes[2], 1);

        // Glitch shorter than DEBOUNCE: never scans, no event
        col_active = 1'b0;
        base = flag_cnt;
        pressed = 16'h0001;
        repeat (4) @(negedge clk_1khz);
        pressed = '0;
        repeat (30) @(negedge clk_1khz);
        check("glitch_no_flag", flag_cnt, base);
        check("glitch_no_scan", int'(col_active), 0);

        // Same column, rows 0 and 2: lowest row wins, no repeat until all up
        base = flag_cnt;
        press_report(16'h0202, 2, 19, "multi_row");
        repeat (40) @(negedge clk_1khz);
        pressed = 16'h0200;
        repeat (30) @(negedge clk_1khz);
        check("multi_row_no_repeat", flag_cnt, base + 1);
        release_all();
        check("multi_row_count", flag_cnt, base + 1);

        // Columns 0 and 2 together: column 0 (row3 -> 14) reported first
        base = flag_cnt;
        press_report(16'h1040, 14, 16, "multi_col");
        release_all();
        check("multi_col_count", flag_cnt, base + 1);

        // Long hold then release bounce: exactly one event
        base = flag_cnt;
        press_report(16'h0400, 9, 22, "hold");
        repeat (178) @(negedge clk_1khz);
        pressed = '0;
        repeat (3) @(negedge clk_1khz);
        pressed = 16'h0400;
        repeat (2) @(negedge clk_1khz);
        release_all();
        check("hold_count", flag_cnt, base + 1);
        check("hold_data_held", int'(data), 9);

        // Reset during SCAN (row1/col3), key still held afterwards
        base = flag_cnt;
        pressed = 16'h0080;
        repeat (14) @(negedge clk_1khz);
        check("pre_reset_scanning", int'(col), 4'b1110);
        rst_n = 1'b0;
        @(negedge clk_1khz);
        check("mid_reset_col", int'(col), 0);
        check("mid_reset_flag", int'(flag), 0);
        check("mid_reset_data", int'(data), 0);
        rst_n = 1'b1;
        press_report(16'h0080, 11, 25, "after_reset");
        release_all();
        check("after_reset_count", flag_cnt, base + 1);

        check("total_events", flag_cnt, 7);
        check("no_double_flag", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
